// File: rtl/pos_embed_pkg.sv
// ============================================================================
// pos_embed_pkg : shared widths and positional-embedding term for pos_embed_add
// Rev 1.0
// ============================================================================
`default_nettype none

package pos_embed_pkg;

  localparam int DATA_W    = 8;
  localparam int SEQ_LEN   = 8;
  localparam int POS_W     = 3;
  localparam int NUM_LANES = 4;

  // +p on even lanes, -p on odd lanes, sign-extended to DATA_W+1 bits
  function automatic logic signed [DATA_W:0] pe_term(input logic [POS_W-1:0] p, input int i);
    logic signed [DATA_W:0] t;
    t = signed'({{(DATA_W+1-POS_W){1'b0}}, p});
    return i[0] ? -t : t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pos_embed_add_sat_add.sv
// ============================================================================
// sat_add : signed DATA_W add of value and term; clamps when POS_EMBED_SAT_EN
//           is defined, otherwise wraps to DATA_W bits with sat tied low.
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_add
  import pos_embed_pkg::*;
(
  input  logic signed [DATA_W-1:0] value,
  input  logic signed [DATA_W:0]   term,
  output logic        [DATA_W-1:0] result,
  output logic                     sat
);

  logic signed [DATA_W:0] wide;

  assign wide = {value[DATA_W-1], value} + term;

`ifdef POS_EMBED_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // operands are at most one bit wider than the result, so top two bits disagreeing means overflow
  assign sat    = wide[DATA_W] ^ wide[DATA_W-1];
  assign result = !sat ? wide[DATA_W-1:0] : (wide[DATA_W] ? SAT_MIN : SAT_MAX);
`else
  logic unused_top;

  assign unused_top = wide[DATA_W];
  assign result     = wide[DATA_W-1:0];
  assign sat        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/pos_embed_add.sv
// ============================================================================
// pos_embed_add : adds a position-dependent term to each token embedding and
//                 registers it behind a one-deep valid/ready stage.
//                 Optional saturation: define POS_EMBED_SAT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pos_embed_add
  import pos_embed_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] embedding_vector0,
  input  logic [DATA_W-1:0] embedding_vector1,
  input  logic [DATA_W-1:0] embedding_vector2,
  input  logic [DATA_W-1:0] embedding_vector3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_vector0,
  output logic [DATA_W-1:0] out_vector1,
  output logic [DATA_W-1:0] out_vector2,
  output logic [DATA_W-1:0] out_vector3,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_last,
  output logic              sat_flag
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(SEQ_LEN - 1);

  logic                 accept;
  logic [POS_W-1:0]     pos_cnt;
  logic [POS_W-1:0]     cur_pos;
  logic                 cur_last;
  logic [DATA_W-1:0]    emb      [NUM_LANES];
  logic [DATA_W-1:0]    sum      [NUM_LANES];
  logic [DATA_W-1:0]    vec_q    [NUM_LANES];
  logic [NUM_LANES-1:0] lane_sat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cur_pos  = in_sof ? '0 : pos_cnt;
  assign cur_last = (cur_pos == LAST_POS);

  assign emb[0] = embedding_vector0;
  assign emb[1] = embedding_vector1;
  assign emb[2] = embedding_vector2;
  assign emb[3] = embedding_vector3;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      sat_add u_sat_add (
        .value  (emb[i]),
        .term   (pe_term(cur_pos, i)),
        .result (sum[i]),
        .sat    (lane_sat[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      pos_cnt   <= '0;
      for (int i = 0; i < NUM_LANES; i++) vec_q[i] <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pos   <= cur_pos;
      out_last  <= cur_last;
      sat_flag  <= |lane_sat;
      pos_cnt   <= cur_last ? '0 : cur_pos + POS_W'(1);
      for (int i = 0; i < NUM_LANES; i++) vec_q[i] <= sum[i];
    end else if (out_ready) begin
      // drained with nothing new: data outputs keep their last value
      out_valid <= 1'b0;
    end
  end

  assign out_vector0 = vec_q[0];
  assign out_vector1 = vec_q[1];
  assign out_vector2 = vec_q[2];
  assign out_vector3 = vec_q[3];

endmodule

`default_nettype wire
